// File: rtl/sprite_palette_mixer_if.sv
// sprite_palette_mixer_if: pixel stream, sprite setup, sprite ROM port, palette write and VGA/status signals of the mixer
interface sprite_palette_mixer_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W = 10,
    parameter int IDX_W = 4,
    parameter int ADDR_W = 8
);
    logic pix_valid_in;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [NUM_SPRITES-1:0] spr_en;
    logic [NUM_SPRITES*COORD_W-1:0] spr_x;
    logic [NUM_SPRITES*COORD_W-1:0] spr_y;
    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
    logic [NUM_SPRITES*IDX_W-1:0] rom_data;
    logic pal_we;
    logic [IDX_W-1:0] pal_waddr;
    logic [23:0] pal_wdata;
    logic coll_clr;
    logic pix_valid_out;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic [NUM_SPRITES-1:0] hit_mask;
    logic collision;
    modport master (
        output pix_valid_in, DrawX, DrawY, spr_en, spr_x, spr_y, rom_data, pal_we, pal_waddr, pal_wdata, coll_clr,
        input rom_addr, pix_valid_out, VGA_R, VGA_G, VGA_B, hit_mask, collision
    );
    modport slave (
        input pix_valid_in, DrawX, DrawY, spr_en, spr_x, spr_y, rom_data, pal_we, pal_waddr, pal_wdata, coll_clr,
        output rom_addr, pix_valid_out, VGA_R, VGA_G, VGA_B, hit_mask, collision
    );
endinterface

// File: rtl/sprite_palette_mixer.sv
// sprite_palette_mixer: 3-stage sprite compositor (Clk, Reset_n; bus carries DrawX/Y in, sprite boxes, ROM addr/data, palette writes, VGA out, hit_mask, collision)
module sprite_palette_mixer #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int IDX_W = 4,
    parameter int COORD_W = 10,
    parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0,
    parameter logic [23:0] BG_RGB = 24'h5C94FC,
    parameter int ADDR_W = $clog2(SPR_W * SPR_H)
) (
    input logic Clk,
    input logic Reset_n,
    sprite_palette_mixer_if.slave bus
);
    logic [NUM_SPRITES-1:0] box_d;
    logic [NUM_SPRITES-1:0] box1;
    logic [NUM_SPRITES-1:0] box2;
    logic [NUM_SPRITES-1:0] opaque;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_d;
    logic v1;
    logic v2;
    logic [23:0] rgb;
    logic [23:0] pal [2**IDX_W];
    // compares run one bit wider so a box hanging off the right/bottom edge never wraps to 0
    always_comb begin
        box_d = '0;
        addr_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            box_d[i] = bus.spr_en[i]
                && {1'b0, bus.DrawX} >= {1'b0, bus.spr_x[i*COORD_W +: COORD_W]}
                && {1'b0, bus.DrawX} < {1'b0, bus.spr_x[i*COORD_W +: COORD_W]} + (COORD_W+1)'(SPR_W)
                && {1'b0, bus.DrawY} >= {1'b0, bus.spr_y[i*COORD_W +: COORD_W]}
                && {1'b0, bus.DrawY} < {1'b0, bus.spr_y[i*COORD_W +: COORD_W]} + (COORD_W+1)'(SPR_H);
            addr_d[i*ADDR_W +: ADDR_W] = box_d[i] ? ADDR_W'((bus.DrawY - bus.spr_y[i*COORD_W +: COORD_W]) * COORD_W'(SPR_W)
                + (bus.DrawX - bus.spr_x[i*COORD_W +: COORD_W])) : '0;
        end
    end
    // rom_data is the ROMs' own registered output, aligned with box2/v2
    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            opaque[i] = box2[i] && bus.rom_data[i*IDX_W +: IDX_W] != TRANSPARENT_IDX;
    end
    // walk from lowest priority up so sprite 0 overwrites last
    always_comb begin
        rgb = BG_RGB;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            rgb = opaque[i] ? pal[bus.rom_data[i*IDX_W +: IDX_W]] : rgb;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            box1 <= '0;
            box2 <= '0;
            bus.rom_addr <= '0;
            bus.pix_valid_out <= 1'b0;
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= 24'h0;
            bus.hit_mask <= '0;
            bus.collision <= 1'b0;
        end else begin
            v1 <= bus.pix_valid_in;
            box1 <= box_d;
            bus.rom_addr <= addr_d;
            v2 <= v1;
            box2 <= box1;
            bus.pix_valid_out <= v2;
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= v2 ? rgb : 24'h0;
            bus.hit_mask <= v2 ? opaque : '0;
            bus.collision <= (v2 && $countones(opaque) >= 2) || (bus.collision && !bus.coll_clr);
        end
    end
    // lookups read the pre-edge contents, so a same-cycle write shows up one pixel later
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            for (int i = 0; i < 2**IDX_W; i++) pal[i] <= 24'h0;
        else if (bus.pal_we)
            pal[bus.pal_waddr] <= bus.pal_wdata;
    end
endmodule

// File: tb/tb_sprite_palette_mixer.sv
// tb_sprite_palette_mixer: directed self-checking bench for sprite_palette_mixer
module tb_sprite_palette_mixer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;
    logic [3:0] rom_mem [4][256];
    sprite_palette_mixer_if bus ();
    sprite_palette_mixer dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk)
        for (int i = 0; i < 4; i++) bus.rom_data[i*4 +: 4] <= rom_mem[i][bus.rom_addr[i*8 +: 8]];
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic pal_wr(logic [3:0] a, logic [23:0] d);
        bus.pal_we = 1'b1;
        bus.pal_waddr = a;
        bus.pal_wdata = d;
        tick();
        bus.pal_we = 1'b0;
    endtask
    task automatic sprite(int i, logic [9:0] x, logic [9:0] y);
        bus.spr_x[i*10 +: 10] = x;
        bus.spr_y[i*10 +: 10] = y;
    endtask
    task automatic px(logic [9:0] x, logic [9:0] y);
        bus.pix_valid_in = 1'b1;
        bus.DrawX = x;
        bus.DrawY = y;
    endtask
    function automatic logic [23:0] vga();
        return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction
    initial begin
        bus.pix_valid_in = 1'b0;
        bus.DrawX = '0;
        bus.DrawY = '0;
        bus.spr_en = '0;
        bus.spr_x = '0;
        bus.spr_y = '0;
        bus.pal_we = 1'b0;
        bus.pal_waddr = '0;
        bus.pal_wdata = '0;
        bus.coll_clr = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int a = 0; a < 256; a++) rom_mem[i][a] = 4'h0;
        tick(2);
        chk("rst_valid", bus.pix_valid_out, 0);
        chk("rst_rgb", vga(), 0);
        chk("rst_hit", bus.hit_mask, 0);
        chk("rst_coll", bus.collision, 0);
        chk("rst_addr", bus.rom_addr, 0);
        rst_n = 1'b1;
        tick();
        pal_wr(5, 24'hB13425);
        rom_mem[0][35] = 4'd5;
        bus.spr_en = 4'b0001;
        sprite(0, 100, 50);
        px(103, 52);
        tick();
        chk("s1_addr", bus.rom_addr[7:0], 35);
        chk("s1_early", bus.pix_valid_out, 0);
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("s1_valid", bus.pix_valid_out, 1);
        chk("s1_rgb", vga(), 24'hB13425);
        chk("s1_hit", bus.hit_mask, 4'b0001);
        tick();
        chk("s1_blank_valid", bus.pix_valid_out, 0);
        chk("s1_blank_rgb", vga(), 0);
        chk("s1_blank_hit", bus.hit_mask, 0);
        pal_wr(3, 24'hFFFFFF);
        pal_wr(7, 24'h123456);
        rom_mem[2][0] = 4'd3;
        bus.spr_en = 4'b0101;
        sprite(0, 200, 200);
        sprite(2, 200, 200);
        px(200, 200);
        tick();
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("transp_rgb", vga(), 24'hFFFFFF);
        chk("transp_hit", bus.hit_mask, 4'b0100);
        chk("transp_coll", bus.collision, 0);
        rom_mem[0][0] = 4'd7;
        px(200, 200);
        tick();
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("prio_rgb", vga(), 24'h123456);
        chk("prio_hit", bus.hit_mask, 4'b0101);
        chk("prio_coll", bus.collision, 1);
        px(200, 200);
        tick();
        bus.pix_valid_in = 1'b0;
        tick();
        bus.coll_clr = 1'b1;
        tick();
        bus.coll_clr = 1'b0;
        chk("clr_set_wins", bus.collision, 1);
        bus.coll_clr = 1'b1;
        tick();
        bus.coll_clr = 1'b0;
        chk("clr_clears", bus.collision, 0);
        tick();
        chk("clr_holds", bus.collision, 0);
        bus.spr_en = 4'b0001;
        sprite(0, 100, 50);
        px(103, 52);
        tick(2);
        bus.pix_valid_in = 1'b0;
        bus.pal_we = 1'b1;
        bus.pal_waddr = 4'd5;
        bus.pal_wdata = 24'h00FF00;
        tick();
        bus.pal_we = 1'b0;
        chk("haz_old", vga(), 24'hB13425);
        tick();
        chk("haz_new", vga(), 24'h00FF00);
        chk("haz_hit", bus.hit_mask, 4'b0001);
        sprite(0, 1016, 50);
        rom_mem[0][39] = 4'd5;
        px(1023, 52);
        tick();
        chk("edge_addr", bus.rom_addr[7:0], 39);
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("edge_rgb", vga(), 24'h00FF00);
        chk("edge_hit", bus.hit_mask, 4'b0001);
        px(0, 52);
        tick();
        chk("nowrap_addr", bus.rom_addr[7:0], 0);
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("nowrap_valid", bus.pix_valid_out, 1);
        chk("nowrap_rgb", vga(), 24'h5C94FC);
        chk("nowrap_hit", bus.hit_mask, 0);
        bus.spr_en = 4'b0101;
        sprite(0, 200, 200);
        px(200, 200);
        tick(3);
        chk("pre_rst_valid", bus.pix_valid_out, 1);
        chk("pre_rst_coll", bus.collision, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.pix_valid_out, 0);
        chk("mid_rst_rgb", vga(), 0);
        chk("mid_rst_hit", bus.hit_mask, 0);
        chk("mid_rst_coll", bus.collision, 0);
        chk("mid_rst_addr", bus.rom_addr, 0);
        bus.pix_valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_valid", bus.pix_valid_out, 0);
        end
        px(200, 200);
        tick();
        bus.pix_valid_in = 1'b0;
        tick(2);
        chk("rst_pal_valid", bus.pix_valid_out, 1);
        chk("rst_pal_rgb", vga(), 0);
        chk("rst_pal_hit", bus.hit_mask, 4'b0101);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
